// File: rtl/mspe_stream_tx.sv
// mspe_stream_tx: packs 32-bit host words into 512-bit stream beats,
// buffers the committed beats, and presents them through a registered
// first-word-fall-through output stage with valid/ready handshaking.
// Optional feature macro: MSPE_STREAM_TX_PKTCNT_EN enables the
// transmitted-packet counter on pkt_count; without it pkt_count is 0.
module mspe_stream_tx #(
    parameter int unsigned BUF_AW = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  in_data,
    input  logic         in_we,
    input  logic         in_last,
    output logic         in_full,
    output logic [511:0] src_data,
    output logic         src_valid,
    output logic         src_sop,
    output logic         src_eop,
    input  logic         src_ready,
    output logic         overflow,
    output logic [31:0]  pkt_count
);

    localparam int unsigned     DEPTH      = 1 << BUF_AW;
    localparam logic [BUF_AW:0] FULL_LEVEL = (BUF_AW + 1)'(DEPTH - 1);

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
    } beat_t;

    // Packer state
    logic [3:0]   lane;
    logic [511:0] acc;
    logic         sop_armed;
    logic [511:0] merged;
    logic         accept;
    logic         commit;

    // Beat buffer state
    beat_t             mem [DEPTH];
    logic [BUF_AW-1:0] wr_ptr;
    logic [BUF_AW-1:0] rd_ptr;
    logic [BUF_AW:0]   mem_cnt;
    logic [BUF_AW:0]   occupancy;
    logic              load;

    // Output stage state
    beat_t out_beat;
    logic  out_valid;
    logic  xfer;

    // Host-side acceptance and beat-close decisions
    always_comb begin
        accept = in_we && !in_full;
        commit = accept && (in_last || (lane == 4'd15));
    end

    // Current partial beat with the incoming word dropped into its lane
    always_comb begin
        merged = acc;
        merged[{lane, 5'd0} +: 32] = in_data;
    end

    // Packer: lane index, partial beat accumulator, start-of-packet tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            lane      <= '0;
            acc       <= '0;
            sop_armed <= 1'b1;
        end else if (accept) begin
            if (commit) begin
                lane      <= '0;
                acc       <= '0;
                sop_armed <= in_last;
            end else begin
                lane <= lane + 4'd1;
                acc  <= merged;
            end
        end
    end

    // Buffer storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (reset && commit) begin
            mem[wr_ptr] <= '{data: merged, sop: sop_armed, eop: in_last};
        end
    end

    // The output register refills from the buffer whenever it is empty or
    // its beat leaves on this edge; a fresh commit always lands in the
    // buffer first, which gives the one-cycle buffer-to-output latency.
    always_comb begin
        xfer      = out_valid && src_ready;
        load      = (mem_cnt != '0) && (!out_valid || src_ready);
        occupancy = mem_cnt + (BUF_AW + 1)'(out_valid);
        in_full   = occupancy >= FULL_LEVEL;
    end

    // Buffer pointers and entry count; commit and pop may coincide
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + BUF_AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + BUF_AW'(1);
            end
            case ({commit, load})
                2'b10:   mem_cnt <= mem_cnt + (BUF_AW + 1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (BUF_AW + 1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Registered head-of-buffer beat; held unchanged while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_beat  <= mem[rd_ptr];
        end else if (src_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky flag for host words written while full
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (in_we && in_full) begin
            overflow <= 1'b1;
        end
    end

`ifdef MSPE_STREAM_TX_PKTCNT_EN
    logic [31:0] pkt_cnt_q;

    // Count packets as their end-of-packet beat is handed to the sink
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_cnt_q <= '0;
        end else if (xfer && out_beat.eop) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_count = pkt_cnt_q;
`else
    assign pkt_count = '0;
`endif

    assign src_valid = out_valid;
    assign src_data  = out_beat.data;
    assign src_sop   = out_beat.sop;
    assign src_eop   = out_beat.eop;

endmodule
